data_mem_responder: RTL and testbench

//  Responder end of the core's data-memory interface: services load/store requests
//  (load, write, addr, wdata, memsize) issued by the RV32 core and returns load data.

---
 rtl/data_mem_responder_pkg.sv | 36 +++
 rtl/data_mem_responder_mem_bank.sv | 31 +++
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 tb/tb_data_mem_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: request sizes, FSM states and byte-lane helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        MS_NONE = 2'b00,
        MS_BYTE = 2'b01,
        MS_HALF = 2'b10,
        MS_WORD = 2'b11
    } memsize_e;

    typedef enum logic {
        ST_IDLE,
        ST_SPLIT
    } state_e;

    // Second-half context of an access, captured at accept.
    typedef struct packed {
        logic        load;
        logic [1:0]  k;
        logic [3:0]  be_hi;
        logic [31:0] wd_hi;
    } req_t;

    // Byte enables across two consecutive words: [3:0] for word w, [7:4] for word w+1.
    function automatic logic [7:0] lane_mask(memsize_e size, logic [1:0] offset);
        logic [7:0] base;
        case (size)
            MS_BYTE: base = 8'h01;
            MS_HALF: base = 8'h03;
            MS_WORD: base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_bank.sv
// Single-port word SRAM with byte-lane writes and registered read data; array is never reset.
module mem_bank #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned AW        = 10,
  parameter string       INIT_FILE = ""
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
      rd_q <= mem[i_addr];
    end
  end

  assign o_rdata = rd_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core data-memory port: checks range, splits word-crossing accesses
// into two SRAM cycles and returns little-endian load data.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE      = 32'h0,
    parameter string       INIT_FILE = ""
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_memsize,
    output logic        o_ready,
    output logic        o_valid,
    output logic [31:0] o_rdata,
    output logic        o_fault
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e        state_q, state_d;
    req_t          req_q, req_d;
    logic [AW-1:0] word_q, word_d;
    logic          valid_q, valid_d;
    logic          fault_q, fault_d;
    logic [23:0]   lo_q, lo_d;

    logic [31:0]   off, w;
    logic [1:0]    k;
    logic [7:0]    be8;
    logic [63:0]   wd64;
    logic          accept, split, fault;

    logic          bank_en;
    logic [AW-1:0] bank_addr;
    logic [3:0]    bank_be;
    logic [31:0]   bank_wdata, bank_rdata;

    assign o_ready = i_rst_n && (state_q == ST_IDLE);
    assign accept  = (i_load || i_write) && o_ready;

    // BASE is word-aligned, so the low offset bits equal the address lane.
    assign off  = i_addr - BASE;
    assign w    = {2'b00, off[31:2]};
    assign k    = off[1:0];
    assign be8  = lane_mask(memsize_e'(i_memsize), k);
    assign wd64 = {32'h0, i_wdata} << {k, 3'b000};

    always_comb begin
        split = i_load ? (k != 2'd0) : (be8[7:4] != 4'b0000);
        fault = (i_load && i_write)
             || (i_write && memsize_e'(i_memsize) == MS_NONE)
             || !(w < DEPTH)
             || (split && !((w + 32'd1) < DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        word_d     = word_q;
        lo_d       = lo_q;
        valid_d    = 1'b0;
        fault_d    = 1'b0;
        bank_en    = 1'b0;
        bank_addr  = w[AW-1:0];
        bank_be    = 4'b0000;
        bank_wdata = wd64[31:0];
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    valid_d = 1'b1;
                    if (fault) begin
                        fault_d = 1'b1;
                    end else begin
                        bank_en     = 1'b1;
                        bank_be     = i_write ? be8[3:0] : 4'b0000;
                        req_d.load  = i_load;
                        req_d.k     = k;
                        req_d.be_hi = i_write ? be8[7:4] : 4'b0000;
                        req_d.wd_hi = wd64[63:32];
                        word_d      = w[AW-1:0] + AW'(1);
                        if (split) begin
                            valid_d = 1'b0;
                            state_d = ST_SPLIT;
                        end
                    end
                end
            end
            ST_SPLIT: begin
                bank_en    = 1'b1;
                bank_addr  = word_q;
                bank_be    = req_q.be_hi;
                bank_wdata = req_q.wd_hi;
                lo_d       = bank_rdata[31:8];
                valid_d    = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            word_q  <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            word_q  <= word_d;
            lo_q    <= lo_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Aligned loads come straight from the bank; split loads join the held upper bytes of
    // word w with the low bytes of word w+1 now on the bank output.
    always_comb begin
        o_rdata = '0;
        if (valid_q && !fault_q && req_q.load) begin
            unique case (req_q.k)
                2'd0: o_rdata = bank_rdata;
                2'd1: o_rdata = {bank_rdata[7:0], lo_q};
                2'd2: o_rdata = {bank_rdata[15:0], lo_q[23:8]};
                2'd3: o_rdata = {bank_rdata[23:0], lo_q[23:16]};
                default: o_rdata = '0;
            endcase
        end
    end

    assign o_valid = valid_q;
    assign o_fault = fault_q;

    mem_bank #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .INIT_FILE(INIT_FILE)
    ) u_bank (
        .i_clk  (i_clk),
        .i_en   (bank_en),
        .i_addr (bank_addr),
        .i_be   (bank_be),
        .i_wdata(bank_wdata),
        .o_rdata(bank_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset-in-split sequence and random
// traffic checked against a byte-array memory model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH  = 64;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int unsigned NBYTES = 4 * DEPTH;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_load, i_write;
    logic [31:0] i_addr, i_wdata;
    logic [1:0]  i_memsize;
    logic        o_ready, o_valid, o_fault;
    logic [31:0] o_rdata;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] mm [NBYTES];

    typedef struct {
        logic        ld;
        logic        wr;
        logic [31:0] off;
        logic [31:0] wdata;
        logic [1:0]  sz;
        logic        fault;
        int          lat;
        logic [31:0] rdata;
        logic [31:0] mask;
    } vec_t;

    vec_t tbl[$];

    data_mem_responder #(
        .DEPTH    (DEPTH),
        .BASE     (BASE),
        .INIT_FILE("")
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (i_load),
        .i_write  (i_write),
        .i_addr   (i_addr),
        .i_wdata  (i_wdata),
        .i_memsize(i_memsize),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o_rdata  (o_rdata),
        .o_fault  (o_fault)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic wr, input logic [31:0] off,
                                input logic [31:0] wdata, input logic [1:0] sz,
                                input logic fault, input int lat,
                                input logic [31:0] rdata, input logic [31:0] mask);
        vec_t v;
        v.ld = ld; v.wr = wr; v.off = off; v.wdata = wdata; v.sz = sz;
        v.fault = fault; v.lat = lat; v.rdata = rdata; v.mask = mask;
        return v;
    endfunction

    // One request, checked against the byte model: an access touches n bytes from the
    // offset; it faults if any lies outside memory, and takes 2 cycles if it spans two words.
    task automatic xact(input logic ld, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] sz, input string tag,
                        output logic [31:0] got_rdata, output logic got_fault, output int got_lat);
        logic [31:0] off, exp_rdata;
        logic        exp_fault;
        int          n, exp_lat, guard;
        off       = addr - BASE;
        n         = ld ? 4 : ((sz == 2'd3) ? 4 : int'(sz));
        exp_fault = (ld && wr) || (wr && sz == 2'd0) ||
                    ((64'(off) + 64'(n)) > 64'(NBYTES));
        exp_lat   = (!exp_fault && (int'(off[1:0]) + n > 4)) ? 2 : 1;
        exp_rdata = '0;
        if (ld && !exp_fault)
            for (int i = 0; i < 4; i++) exp_rdata[8*i +: 8] = mm[int'(off) + i];

        guard = 0;
        while (!o_ready && guard < 8) begin
            @(posedge i_clk); #1;
            guard++;
        end
        chk({tag, ":ready"}, 32'(o_ready), 32'd1);
        i_load = ld; i_write = wr; i_addr = addr; i_wdata = wdata; i_memsize = sz;
        @(posedge i_clk); #1;
        i_load = 1'b0; i_write = 1'b0;
        if (exp_lat == 2) chk({tag, ":ready_split"}, 32'(o_ready), 32'd0);
        got_lat = 1;
        while (!o_valid && got_lat < 5) begin
            @(posedge i_clk); #1;
            got_lat++;
        end
        got_fault = o_fault;
        got_rdata = o_rdata;
        chk({tag, ":latency"}, 32'(got_lat), 32'(exp_lat));
        chk({tag, ":fault"}, 32'(got_fault), 32'(exp_fault));
        if (ld || exp_fault) chk({tag, ":rdata"}, got_rdata, exp_rdata);
        if (wr && !exp_fault)
            for (int i = 0; i < n; i++) mm[int'(off) + i] = wdata[8*i +: 8];
    endtask

    initial begin
        logic [31:0] r;
        logic        f;
        int          l;
        logic        ld, wr;
        logic [1:0]  sz;
        logic [31:0] off;
        int unsigned pick;

        i_rst_n = 1'b0; i_load = 1'b0; i_write = 1'b0;
        i_addr = '0; i_wdata = '0; i_memsize = 2'd0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset:ready", 32'(o_ready), 32'd0);
        chk("reset:valid", 32'(o_valid), 32'd0);
        chk("reset:fault", 32'(o_fault), 32'd0);
        chk("reset:rdata", o_rdata, 32'd0);
        i_rst_n = 1'b1;
        #1;
        chk("release:ready", 32'(o_ready), 32'd1);

        for (int unsigned wi = 0; wi < DEPTH; wi++)
            xact(1'b0, 1'b1, BASE + 32'(4 * wi), $urandom, 2'd3, $sformatf("init%0d", wi), r, f, l);

        tbl.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 2'd3, 0, 1, 32'h0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h10, 32'h0, 2'd0, 0, 1, 32'hDEADBEEF, 32'hFFFFFFFF));
        tbl.push_back(mk(0, 1, 32'h11, 32'h000000AA, 2'd1, 0, 1, 32'h0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h10, 32'h0, 2'd3, 0, 1, 32'hDEADAAEF, 32'hFFFFFFFF));
        tbl.push_back(mk(1, 0, 32'h11, 32'h0, 2'd0, 0, 2, 32'h00DEADAA, 32'h00FFFFFF));
        tbl.push_back(mk(0, 1, 32'h23, 32'h11223344, 2'd3, 0, 2, 32'h0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h20, 32'h0, 2'd0, 0, 1, 32'h44000000, 32'hFF000000));
        tbl.push_back(mk(1, 0, 32'h24, 32'h0, 2'd0, 0, 1, 32'h00112233, 32'h00FFFFFF));
        tbl.push_back(mk(1, 0, 32'h100, 32'h0, 2'd0, 1, 1, 32'h0, 32'hFFFFFFFF));
        tbl.push_back(mk(0, 1, 32'hFE, 32'hCAFEF00D, 2'd3, 1, 1, 32'h0, 32'hFFFFFFFF));
        tbl.push_back(mk(1, 0, 32'hFC, 32'h0, 2'd0, 0, 1, 32'h0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h10, 32'h12345678, 2'd3, 1, 1, 32'h0, 32'hFFFFFFFF));
        tbl.push_back(mk(0, 1, 32'h10, 32'h12345678, 2'd0, 1, 1, 32'h0, 32'hFFFFFFFF));
        tbl.push_back(mk(1, 0, 32'h10, 32'h0, 2'd0, 0, 1, 32'hDEADAAEF, 32'hFFFFFFFF));
        tbl.push_back(mk(1, 0, 32'hFFFFFFFC, 32'h0, 2'd0, 1, 1, 32'h0, 32'hFFFFFFFF));
        tbl.push_back(mk(1, 0, 32'hFD, 32'h0, 2'd0, 1, 1, 32'h0, 32'hFFFFFFFF));
        tbl.push_back(mk(0, 1, 32'hFF, 32'h0000BEEF, 2'd2, 1, 1, 32'h0, 32'hFFFFFFFF));
        tbl.push_back(mk(0, 1, 32'hFF, 32'h00000077, 2'd1, 0, 1, 32'h0, 32'h0));
        tbl.push_back(mk(1, 0, 32'hFC, 32'h0, 2'd0, 0, 1, 32'h77000000, 32'hFF000000));
        tbl.push_back(mk(0, 1, 32'h2F, 32'h0000BEEF, 2'd2, 0, 2, 32'h0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h2C, 32'h00001234, 2'd2, 0, 1, 32'h0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h2C, 32'h0, 2'd0, 0, 1, 32'hEF001234, 32'hFF00FFFF));
        tbl.push_back(mk(1, 0, 32'h2E, 32'h0, 2'd0, 0, 2, 32'h00BEEF00, 32'h00FFFF00));

        for (int t = 0; t < tbl.size(); t++) begin
            xact(tbl[t].ld, tbl[t].wr, BASE + tbl[t].off, tbl[t].wdata, tbl[t].sz,
                 $sformatf("tbl%0d", t), r, f, l);
            chk($sformatf("tbl%0d:vec_fault", t), 32'(f), 32'(tbl[t].fault));
            chk($sformatf("tbl%0d:vec_latency", t), 32'(l), 32'(tbl[t].lat));
            if (tbl[t].mask != 32'h0)
                chk($sformatf("tbl%0d:vec_rdata", t), r & tbl[t].mask, tbl[t].rdata & tbl[t].mask);
        end

        // Fault and valid are single-cycle pulses.
        xact(1'b1, 1'b0, BASE + 32'h100, 32'h0, 2'd0, "pulse", r, f, l);
        @(posedge i_clk); #1;
        chk("pulse:valid_drop", 32'(o_valid), 32'd0);
        chk("pulse:fault_drop", 32'(o_fault), 32'd0);

        // Reset during the second half of a split store abandons that half.
        i_load = 1'b0; i_write = 1'b1; i_addr = BASE + 32'h33;
        i_wdata = 32'h55667788; i_memsize = 2'd3;
        @(posedge i_clk); #1;
        i_write = 1'b0;
        chk("rst_split:ready_split", 32'(o_ready), 32'd0);
        i_rst_n = 1'b0;
        #1;
        chk("rst_split:ready_in_reset", 32'(o_ready), 32'd0);
        chk("rst_split:valid_in_reset", 32'(o_valid), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        #1;
        chk("rst_split:ready_release", 32'(o_ready), 32'd1);
        mm[8'h33] = 8'h88;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            chk($sformatf("rst_split:no_valid%0d", c), 32'(o_valid), 32'd0);
        end
        xact(1'b1, 1'b0, BASE + 32'h30, 32'h0, 2'd0, "rst_split:w30", r, f, l);
        chk("rst_split:byte33", 32'(r[31:24]), 32'h88);
        xact(1'b1, 1'b0, BASE + 32'h34, 32'h0, 2'd0, "rst_split:w34", r, f, l);

        for (int it = 0; it < 400; it++) begin
            pick = $urandom_range(0, 99);
            ld   = (pick < 45);
            wr   = (pick >= 45) || (pick < 3);
            sz   = 2'($urandom_range(0, 3));
            if (wr && $urandom_range(0, 9) != 0) sz = 2'($urandom_range(1, 3));
            off  = 32'($urandom_range(0, NBYTES + 7));
            if ($urandom_range(0, 19) == 0) off = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            xact(ld, wr, BASE + off, $urandom, sz, $sformatf("rnd%0d", it), r, f, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
